// File: rtl/add_serial_sched_if.sv
// Bundle of requester, adder and response signals for the shared serial-adder scheduler.
// Latency: none (wiring only).
// Backpressure: the response side uses rsp_valid/rsp_ready; requesters hold req until gnt.
interface add_serial_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    // Requester side
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;

    // Shared adder side
    logic                  add_start;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_done;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;

    // Response side
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_err;
    logic                  rsp_ready;

    // Scheduler view
    modport master (
        input  req, a_in, b_in, add_done, add_sum, add_cout, rsp_ready,
        output gnt, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err
    );

    // Environment view: requesters, adder and response consumer
    modport slave (
        output req, a_in, b_in, add_done, add_sum, add_cout, rsp_ready,
        input  gnt, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err
    );
endinterface

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters, with watchdog abort.
// Latency: gnt/add_start 1 cycle after req seen in IDLE; rsp_valid 1 cycle after add_done; min 4 cycles/op.
// Backpressure: response held stable until rsp_valid && rsp_ready; no new grant until it is accepted.
module add_serial_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    add_serial_sched_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [4:0]       wdog;
    logic [4:0]       wdog_nxt;

    logic [NREQ-1:0]  gnt_q;
    logic             add_start_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_err_q;

    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [NREQ-1:0]  pick_oh;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;

    // Rotate the request vector so bit 0 is the requester just above the last one served,
    // then take the lowest set bit and map it back to an absolute requester index.
    always_comb begin
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        int                first;
        int                idx;
        dbl   = {bus.req, bus.req};
        rot   = NREQ'(dbl >> (int'(last) + 1));
        first = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                first = j;
            end
        end
        idx = int'(last) + 1 + first;
        if (idx >= NREQ) begin
            idx = idx - NREQ;
        end
        pick_vld = |rot;
        pick_id  = IDW'(idx);
    end

    // Operand mux and one-hot grant for the chosen requester.
    always_comb begin
        pick_a  = '0;
        pick_b  = '0;
        pick_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_oh[i] = 1'b1;
                pick_a     = bus.a_in[i*WIDTH +: WIDTH];
                pick_b     = bus.b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Watchdog counts completed WAIT cycles; expiry is judged on the incremented value.
    assign wdog_nxt = wdog + 5'd1;

    // Scheduler FSM: grant, issue, wait for the adder (or time out), then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= IDW'(NREQ - 1);
            wdog        <= '0;
            gnt_q       <= '0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // gnt and add_start are single-cycle pulses that only live in ISSUE
            gnt_q       <= '0;
            add_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        add_a_q     <= pick_a;
                        add_b_q     <= pick_b;
                        rsp_id_q    <= pick_id;
                        gnt_q       <= pick_oh;
                        add_start_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // add_done is not looked at here: it cannot belong to this operation yet
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.add_done) begin
                        // completion beats a watchdog expiring in the same cycle
                        rsp_sum_q   <= bus.add_sum;
                        rsp_cout_q  <= bus.add_cout;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (wdog_nxt == 5'(TIMEOUT)) begin
                        rsp_sum_q   <= '0;
                        rsp_cout_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog_nxt;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        last        <= rsp_id_q;
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.add_start = add_start_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_err   = rsp_err_q;

    // Structural guarantees of the grant/start pulses.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_issue:  assert property (@(posedge clk) disable iff (!rst_n) (gnt_q != '0) |-> (state == ISSUE));
    a_start_gnt:  assert property (@(posedge clk) disable iff (!rst_n) add_start_q == (gnt_q != '0));

endmodule

// File: tb/tb_add_serial_sched.sv
module tb_add_serial_sched;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 31;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_serial_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus();

    add_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit adder_en = 1'b1;
    int adder_delay = 1;

    // Serial adder stand-in: add_done pulses adder_delay cycles after add_start is seen.
    initial begin : adder_model
        int         cnt;
        bit         busy;
        logic [8:0] res;
        cnt = 0;
        busy = 1'b0;
        res = '0;
        bus.add_done = 1'b0;
        bus.add_sum  = '0;
        bus.add_cout = 1'b0;
        forever begin
            @(negedge clk);
            bus.add_done = 1'b0;
            if (rst_n !== 1'b1) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    bus.add_done = 1'b1;
                    bus.add_sum  = res[7:0];
                    bus.add_cout = res[8];
                    busy = 1'b0;
                end
            end else if (bus.add_start === 1'b1 && adder_en) begin
                busy = 1'b1;
                cnt  = adder_delay;
                res  = {1'b0, bus.add_a} + {1'b0, bus.add_b};
            end
        end
    end

    initial begin : global_guard
        #100000;
        $display("FAIL tb_timeout: simulation still running at 100us");
        $fatal(1);
    end

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.a_in[i*WIDTH +: WIDTH] = a;
        bus.b_in[i*WIDTH +: WIDTH] = b;
    endtask

    // Bounded waits: n is the number of negedges advanced until the event (or the bound).
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt === '0 && n < 100);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rsp_valid !== 1'b1 && n < 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.gnt, bus.add_start, bus.rsp_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_pulses: gnt=%b start=%b valid=%b, want all 0", bus.gnt, bus.add_start, bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_err, bus.rsp_cout} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: err=%b cout=%b, want 0 0", bus.rsp_err, bus.rsp_cout);
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.rsp_sum, bus.rsp_id} !== 26'h0) begin
            failures++;
            $display("FAIL reset_data: add_a=%h add_b=%h sum=%h id=%0d, want 0", bus.add_a, bus.add_b, bus.rsp_sum, bus.rsp_id);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0 || bus.add_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b start=%b, want 0 0", bus.gnt, bus.add_start);
        end
    endtask

    task automatic test_single();
        int n;
        adder_en = 1'b1;
        adder_delay = 9;
        bus.rsp_ready = 1'b0;
        set_lane(0, 8'h3C, 8'h0F);
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.add_start !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gnt=%b start=%b, want 0001 1", bus.gnt, bus.add_start);
        end
        checks++;
        if (bus.add_a !== 8'h3C || bus.add_b !== 8'h0F) begin
            failures++;
            $display("FAIL single_operands: a=%h b=%h, want 3c 0f", bus.add_a, bus.add_b);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0 || bus.add_start !== 1'b0 || bus.add_a !== 8'h3C) begin
            failures++;
            $display("FAIL single_wait: gnt=%b start=%b a=%h, want 0000 0 3c", bus.gnt, bus.add_start, bus.add_a);
        end
        wait_rsp(n);
        checks++;
        if (n !== 9 || bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: rsp_valid=%b at cycle %0d, want 1 at cycle 11", bus.rsp_valid, n + 2);
        end
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== 8'h4B || bus.rsp_cout !== 1'b0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: id=%0d sum=%h cout=%b err=%b, want 0 4b 0 0", bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: rsp_valid=%b after handshake, want 0", bus.rsp_valid);
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        adder_delay = 1;
        bus.rsp_ready = 1'b1;
        set_lane(2, 8'hFF, 8'h01);
        bus.req = 4'b0100;
        wait_gnt(n);
        checks++;
        if (bus.gnt !== 4'b0100 || n !== 1) begin
            failures++;
            $display("FAIL ovf_grant: gnt=%b after %0d cycles, want 0100 after 1", bus.gnt, n);
        end
        bus.req = 4'b0000;
        wait_rsp(n);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_sum !== 8'h00 || bus.rsp_cout !== 1'b1 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_rsp: valid=%b id=%0d sum=%h cout=%b err=%b, want 1 2 00 1 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_err);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int n;
        int exp_order [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_lane(i, 8'(8'h11 * (i + 1)), 8'(8'h22 * (i + 1)));
        adder_delay = 1;
        bus.rsp_ready = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            wait_gnt(n);
            checks++;
            if (bus.gnt !== (4'b0001 << exp_order[k])) begin
                failures++;
                $display("FAIL fair_grant[%0d]: gnt=%b, want requester %0d", k, bus.gnt, exp_order[k]);
            end
            checks++;
            if (n !== ((k == 0) ? 1 : 4)) begin
                failures++;
                $display("FAIL fair_spacing[%0d]: %0d cycles since previous, want %0d", k, n, (k == 0) ? 1 : 4);
            end
            if (k == 5) bus.req = 4'b1010;
            if (k == 8) bus.req = 4'b0000;
        end
        repeat (4) @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        bit stable = 1'b1;
        bit quiet  = 1'b1;
        adder_delay = 1;
        bus.rsp_ready = 1'b0;
        set_lane(0, 8'h12, 8'h34);
        bus.req = 4'b0001;
        wait_gnt(n);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL bp_grant: gnt=%b, want 0001", bus.gnt);
        end
        bus.req = 4'b1110;
        wait_rsp(n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 8'h46 ||
                bus.rsp_cout !== 1'b0 || bus.rsp_err !== 1'b0) stable = 1'b0;
            if (bus.gnt !== 4'b0 || bus.add_start !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: valid=%b id=%0d sum=%h cout=%b err=%b, want 1 0 46 0 0 throughout",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_err);
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL bp_quiet: gnt/add_start seen while response pending, want none");
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0) begin
            failures++;
            $display("FAIL bp_release: valid=%b gnt=%b one cycle after accept, want 0 0000", bus.rsp_valid, bus.gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL bp_next_grant: gnt=%b two cycles after accept, want 0010", bus.gnt);
        end
        bus.req = 4'b0000;
        wait_rsp(n);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        int n;
        int total;
        bit         t_en   [3] = '{1'b0, 1'b1, 1'b1};
        int         t_dly  [3] = '{1, 31, 32};
        logic [7:0] t_a    [3] = '{8'h55, 8'h80, 8'h80};
        logic [7:0] t_b    [3] = '{8'h66, 8'h90, 8'h90};
        logic       t_err  [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] t_sum  [3] = '{8'h00, 8'h10, 8'h00};
        logic       t_cout [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            adder_en = t_en[t];
            adder_delay = t_dly[t];
            bus.rsp_ready = 1'b0;
            set_lane(0, t_a[t], t_b[t]);
            bus.req = 4'b0001;
            wait_gnt(n);
            total = n;
            bus.req = 4'b0000;
            wait_rsp(n);
            total = total + n;
            checks++;
            if (bus.rsp_valid !== 1'b1 || total !== TIMEOUT + 2) begin
                failures++;
                $display("FAIL wd_latency[%0d]: rsp_valid=%b at cycle %0d, want 1 at cycle %0d", t, bus.rsp_valid, total, TIMEOUT + 2);
            end
            checks++;
            if (bus.rsp_err !== t_err[t] || bus.rsp_sum !== t_sum[t] || bus.rsp_cout !== t_cout[t] || bus.rsp_id !== 2'd0) begin
                failures++;
                $display("FAIL wd_rsp[%0d]: err=%b sum=%h cout=%b id=%0d, want %b %h %b 0",
                         t, bus.rsp_err, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, t_err[t], t_sum[t], t_cout[t]);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            @(negedge clk);
        end
        adder_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        bit quiet = 1'b1;
        adder_en = 1'b1;
        adder_delay = 9;
        bus.rsp_ready = 1'b0;
        set_lane(2, 8'h21, 8'h43);
        bus.req = 4'b0100;
        wait_gnt(n);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL rm_grant: gnt=%b, want 0100", bus.gnt);
        end
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.add_a !== 8'h21 || bus.add_b !== 8'h43) begin
            failures++;
            $display("FAIL rm_hold: a=%h b=%h in WAIT, want 21 43", bus.add_a, bus.add_b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.add_start, bus.rsp_valid, bus.rsp_err, bus.rsp_cout,
             bus.add_a, bus.add_b, bus.rsp_sum, bus.rsp_id} !== 34'h0) begin
            failures++;
            $display("FAIL rm_async_clear: a=%h b=%h sum=%h id=%0d valid=%b, want all 0",
                     bus.add_a, bus.add_b, bus.rsp_sum, bus.rsp_id, bus.rsp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.add_start !== 1'b0 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL rm_quiet: add_start or rsp_valid seen while in reset, want none");
        end
        rst_n = 1'b1;
        bus.req = 4'b1111;
        wait_gnt(n);
        checks++;
        if (bus.gnt !== 4'b0001 || n !== 1) begin
            failures++;
            $display("FAIL rm_first_grant: gnt=%b after %0d cycles, want 0001 after 1", bus.gnt, n);
        end
        bus.req = 4'b0000;
        bus.rsp_ready = 1'b1;
        wait_rsp(n);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rm_after_rsp: valid=%b id=%0d err=%b, want 1 0 0", bus.rsp_valid, bus.rsp_id, bus.rsp_err);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin : main
        rst_n = 1'b0;
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_serial_sched.md
# add_serial_sched

Round-robin scheduler that shares one bit-serial 8-bit adder among `NREQ` requesters. It grants one requester at a time and latches that requester's operands. It then starts the adder, waits for completion with a watchdog, and returns the sum, carry and requester ID over a valid/ready response port. It sits between the client logic and the single shared serial-adder datapath.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 8, operand/sum width.
- `TIMEOUT`, 31, max WAIT cycles before abort (5-bit counter; 1..31).
- `IDW`, 2, requester ID width, ≥ clog2(NREQ).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester request level.
- `a_in`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- `b_in`  in  NREQ*WIDTH  operand B, same packing.
- `gnt`  out  NREQ  one-hot, 1-cycle pulse: operands of that requester latched.
- `add_start`  out  1  1-cycle start pulse to adder.
- `add_a`, `add_b`  out  WIDTH  latched operands to adder, stable from ISSUE through WAIT.
- `add_done`  in  1  adder completion pulse.
- `add_sum`  in  WIDTH  adder result, valid with `add_done`.
- `add_cout`  in  1  adder carry-out, valid with `add_done`.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  IDW  granted requester index.
- `rsp_sum`  out  WIDTH  result.
- `rsp_cout`  out  1  carry-out.
- `rsp_err`  out  1  watchdog abort flag.
- `rsp_ready`  in  1  response accepted.

## Operation
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding, all registered outputs).
- IDLE: if any `req` bit set, select the first set bit searching upward (mod NREQ) from `last+1`. Latch its `a_in`/`b_in` into `add_a`/`add_b`, store ID, and go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE (1 cycle): `gnt[id]`=1, `add_start`=1, clear watchdog, go to WAIT. An `add_done` seen in ISSUE is ignored.
- WAIT: `add_a`/`add_b` held. On `add_done`: capture `add_sum`/`add_cout` into `rsp_sum`/`rsp_cout`, set `rsp_err`=0, go to RESP.
  - Otherwise increment watchdog. When watchdog = TIMEOUT with no `add_done`: `rsp_sum`=0, `rsp_cout`=0, `rsp_err`=1, go to RESP.
- RESP: `rsp_valid`=1. All `rsp_*` are stable until `rsp_valid && rsp_ready`. On that handshake: `last`←id, `rsp_valid`←0, go to IDLE.
- Requesters hold `req` and operands until their `gnt`. Requests dropped before grant are ignored. `req` is not sampled outside IDLE.
- The sum is the adder's WIDTH-bit result; overflow is reported only via `rsp_cout`, with no saturation.
- Reset values: state IDLE; `gnt`, `add_start`, `rsp_valid`, `rsp_err`, `rsp_cout` = 0; `add_a`, `add_b`, `rsp_sum`, `rsp_id` = 0; `last` = NREQ-1 so requester 0 has priority first; watchdog = 0.
- Reset asserted mid-operation: immediate return to reset values. The in-flight operation is dropped with no response; the adder sees no further `add_start`.

## Timing
- `req` high in IDLE at cycle 0 → `gnt` and `add_start` high in cycle 1 (ISSUE) → WAIT from cycle 2.
- `add_done` in WAIT cycle k → `rsp_valid` high in cycle k+1.
- `rsp_ready` high with `rsp_valid` in cycle r → IDLE in r+1 → earliest next `gnt` in r+2.
- Minimum 4 cycles per operation (adder done in first WAIT cycle, `rsp_ready` tied high).
- Watchdog: `add_done` absent for TIMEOUT consecutive WAIT cycles (cycles 2..TIMEOUT+1) → `rsp_valid` with `rsp_err` in cycle TIMEOUT+2.
- `add_done` in the same cycle the watchdog expires: `add_done` wins, `rsp_err`=0.
- At most one `gnt` bit and at most one `add_start` per operation. `gnt` is never high outside ISSUE.

## Test plan
- Single request: `req`=0001, a=0x3C, b=0x0F, adder model done after 9 cycles → `gnt`=0001 in cycle 1; `rsp_valid` with id=0, sum=0x4B, cout=0, err=0.
- Overflow: requester 2, a=0xFF, b=0x01 → `rsp_id`=2, sum=0x00, cout=1.
- Fairness: `req`=1111 held, ready tied high → grant order 0,1,2,3,0,1. Then `req`=1010 after grant 1 → next grants 3,1,3.
- Backpressure: `rsp_ready` low for 5 cycles in RESP → `rsp_*` stable, no `gnt` or `add_start`; release → IDLE next cycle.
- Watchdog: `add_done` never asserted → `rsp_valid` 33 cycles after `req` (TIMEOUT=31) with err=1, sum=0. Then `add_done` at exactly watchdog expiry → err=0, sum captured.
- Reset mid-WAIT: pull `rst_n` low during WAIT → all outputs 0 immediately, no response. After release, `req`=1111 → first grant to requester 0.
